// File: rtl/trace_gen_pkg.sv
// Shared definitions for the CPU trace line generator: FSM encoding, ASCII
// punctuation of the trace line format and digit-to-ASCII helpers.
package trace_gen_pkg;

   localparam logic [13:0] TIME_MAX = 14'd9999;

   localparam logic [7:0] CARET  = 8'h5e;
   localparam logic [7:0] AT     = 8'h40;
   localparam logic [7:0] COLON  = 8'h3a;
   localparam logic [7:0] SPACE  = 8'h20;
   localparam logic [7:0] DOLLAR = 8'h24;
   localparam logic [7:0] STAR   = 8'h2a;
   localparam logic [7:0] LT     = 8'h3c;
   localparam logic [7:0] EQ     = 8'h3d;
   localparam logic [7:0] HASH   = 8'h23;

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_CONV  = 4'd1;
   localparam logic [3:0] ST_CARET = 4'd2;
   localparam logic [3:0] ST_TIME  = 4'd3;
   localparam logic [3:0] ST_AT    = 4'd4;
   localparam logic [3:0] ST_PC    = 4'd5;
   localparam logic [3:0] ST_COLON = 4'd6;
   localparam logic [3:0] ST_SP1   = 4'd7;
   localparam logic [3:0] ST_TAG   = 4'd8;
   localparam logic [3:0] ST_FIELD = 4'd9;
   localparam logic [3:0] ST_SP2   = 4'd10;
   localparam logic [3:0] ST_LT    = 4'd11;
   localparam logic [3:0] ST_EQ    = 4'd12;
   localparam logic [3:0] ST_SP3   = 4'd13;
   localparam logic [3:0] ST_DATA  = 4'd14;
   localparam logic [3:0] ST_HASH  = 4'd15;

   typedef enum logic [3:0] {
      S_IDLE  = ST_IDLE,
      S_CONV  = ST_CONV,
      S_CARET = ST_CARET,
      S_TIME  = ST_TIME,
      S_AT    = ST_AT,
      S_PC    = ST_PC,
      S_COLON = ST_COLON,
      S_SP1   = ST_SP1,
      S_TAG   = ST_TAG,
      S_FIELD = ST_FIELD,
      S_SP2   = ST_SP2,
      S_LT    = ST_LT,
      S_EQ    = ST_EQ,
      S_SP3   = ST_SP3,
      S_DATA  = ST_DATA,
      S_HASH  = ST_HASH
   } state_e;

   // Lowercase hex: 'a' - 10 = 8'h57.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
   endfunction

   function automatic logic [7:0] dec_ascii(input logic [3:0] digit);
      dec_ascii = 8'h30 + {4'h0, digit};
   endfunction

endpackage

// File: rtl/cpu_trace_gen_if.sv
// Event-in / character-out handshake bundle of the trace generator.
interface cpu_trace_gen_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_mem;
   logic [13:0] in_time;
   logic [31:0] in_pc;
   logic [4:0]  in_reg;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic        out_valid;
   logic [7:0]  out_char;
   logic        out_ready;

   modport master (
      output in_valid, in_is_mem, in_time, in_pc, in_reg, in_addr, in_data, out_ready,
      input  in_ready, out_valid, out_char
   );

   modport slave (
      input  in_valid, in_is_mem, in_time, in_pc, in_reg, in_addr, in_data, out_ready,
      output in_ready, out_valid, out_char
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: saturates the 14-bit input to TIME_MAX on
// start, then produces four BCD digits after exactly 14 clock cycles.
module bin2bcd_seq
   import trace_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic [13:0] i_bin,
   output logic        o_done,
   output logic [15:0] o_bcd
);
   logic [13:0] r_bin;
   logic [15:0] r_bcd;
   logic [3:0]  r_cnt;
   logic [15:0] w_adj;
   logic [13:0] w_sat;

   assign w_sat = (i_bin > TIME_MAX) ? TIME_MAX : i_bin;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_adj
         assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                   (r_bcd[gi*4 +: 4] + 4'd3) : r_bcd[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_bin <= w_sat;
         r_bcd <= '0;
         r_cnt <= 4'd14;
      end else if (r_cnt != 4'd0) begin
         {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
         r_cnt          <= r_cnt - 4'd1;
      end
   end

   // Flags the cycle whose closing edge performs the final step, so the
   // consumer can use o_bcd on the very next cycle.
   assign o_done = (r_cnt == 4'd1);
   assign o_bcd  = r_bcd;

endmodule

// File: rtl/cpu_trace_gen.sv
// Formats one write-back event into an ASCII trace line, one char per handshake.
// Build option TRACE_GEN_ZERO_PAD_EN: fixed-width zero-padded time/reg fields.
module cpu_trace_gen
   import trace_gen_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   cpu_trace_gen_if.slave bus
);
   state_e      r_state;
   state_e      w_state_next;
   logic        r_is_mem;
   logic [31:0] r_pc;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [4:0]  r_reg;
   logic [2:0]  r_nib;
   logic [1:0]  r_dig;

   logic        w_accept;
   logic        w_emit;
   logic        w_fire;
   logic        w_conv_done;
   logic [15:0] w_bcd;
   logic [3:0]  w_reg_tens;
   logic [3:0]  w_reg_units;
   logic [1:0]  w_time_msd;
   logic        w_reg_msd;
   logic [31:0] w_nib_src;
   logic [3:0]  w_nib;
   logic [3:0]  w_time_digit;
   logic [7:0]  w_char;

   assign bus.in_ready  = (r_state == S_IDLE);
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign w_emit        = (r_state != S_IDLE) && (r_state != S_CONV);
   assign w_fire        = w_emit && bus.out_ready;
   assign bus.out_valid = w_emit;
   assign bus.out_char  = w_char;

   bin2bcd_seq u_bcd (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_accept),
      .i_bin   (bus.in_time),
      .o_done  (w_conv_done),
      .o_bcd   (w_bcd)
   );

   always_comb begin
      w_reg_tens  = 4'd0;
      w_reg_units = r_reg[3:0];
      if (r_reg >= 5'd30) begin
         w_reg_tens  = 4'd3;
         w_reg_units = 4'(r_reg - 5'd30);
      end else if (r_reg >= 5'd20) begin
         w_reg_tens  = 4'd2;
         w_reg_units = 4'(r_reg - 5'd20);
      end else if (r_reg >= 5'd10) begin
         w_reg_tens  = 4'd1;
         w_reg_units = 4'(r_reg - 5'd10);
      end
   end

`ifdef TRACE_GEN_ZERO_PAD_EN
   assign w_time_msd = 2'd3;
   assign w_reg_msd  = 1'b1;
`else
   // Index of the most significant non-zero digit; 0 still prints one digit.
   assign w_time_msd = (w_bcd[15:12] != 4'd0) ? 2'd3 :
                       (w_bcd[11:8]  != 4'd0) ? 2'd2 :
                       (w_bcd[7:4]   != 4'd0) ? 2'd1 : 2'd0;
   assign w_reg_msd  = (w_reg_tens != 4'd0);
`endif

   assign w_time_digit = w_bcd[{r_dig, 2'b00} +: 4];
   assign w_nib_src    = (r_state == S_PC)    ? r_pc   :
                         (r_state == S_FIELD) ? r_addr : r_data;
   assign w_nib        = w_nib_src[{r_nib, 2'b00} +: 4];

   always_comb begin
      w_char = 8'h00;
      case (r_state)
         S_CARET: w_char = CARET;
         S_TIME:  w_char = dec_ascii(w_time_digit);
         S_AT:    w_char = AT;
         S_PC:    w_char = hex_ascii(w_nib);
         S_COLON: w_char = COLON;
         S_SP1:   w_char = SPACE;
         S_TAG:   w_char = r_is_mem ? STAR : DOLLAR;
         S_FIELD: w_char = r_is_mem ? hex_ascii(w_nib) :
                           dec_ascii(r_dig[0] ? w_reg_tens : w_reg_units);
         S_SP2:   w_char = SPACE;
         S_LT:    w_char = LT;
         S_EQ:    w_char = EQ;
         S_SP3:   w_char = SPACE;
         S_DATA:  w_char = hex_ascii(w_nib);
         S_HASH:  w_char = HASH;
         default: w_char = 8'h00;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)    w_state_next = S_CONV;
         S_CONV:  if (w_conv_done) w_state_next = S_CARET;
         S_CARET: if (w_fire) w_state_next = S_TIME;
         S_TIME:  if (w_fire && r_dig == 2'd0) w_state_next = S_AT;
         S_AT:    if (w_fire) w_state_next = S_PC;
         S_PC:    if (w_fire && r_nib == 3'd0) w_state_next = S_COLON;
         S_COLON: if (w_fire) w_state_next = S_SP1;
         S_SP1:   if (w_fire) w_state_next = S_TAG;
         S_TAG:   if (w_fire) w_state_next = S_FIELD;
         S_FIELD: if (w_fire && (r_is_mem ? (r_nib == 3'd0) : (r_dig == 2'd0)))
                     w_state_next = S_SP2;
         S_SP2:   if (w_fire) w_state_next = S_LT;
         S_LT:    if (w_fire) w_state_next = S_EQ;
         S_EQ:    if (w_fire) w_state_next = S_SP3;
         S_SP3:   if (w_fire) w_state_next = S_DATA;
         S_DATA:  if (w_fire && r_nib == 3'd0) w_state_next = S_HASH;
         S_HASH:  if (w_fire) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // The nibble counter is loaded once per line; each 8-digit field leaves it
   // wrapped back to 7, ready for the next hex field.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_is_mem <= 1'b0;
         r_pc     <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_reg    <= '0;
         r_nib    <= '0;
         r_dig    <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_is_mem <= bus.in_is_mem;
            r_pc     <= bus.in_pc;
            r_addr   <= bus.in_addr;
            r_data   <= bus.in_data;
            r_reg    <= bus.in_reg;
            r_nib    <= 3'd7;
            r_dig    <= 2'd0;
         end else if (w_fire) begin
            case (r_state)
               S_CARET: r_dig <= w_time_msd;
               S_TIME:  r_dig <= r_dig - 2'd1;
               S_TAG:   r_dig <= {1'b0, w_reg_msd};
               S_PC,
               S_DATA:  r_nib <= r_nib - 3'd1;
               S_FIELD: begin
                  if (r_is_mem) r_nib <= r_nib - 3'd1;
                  else          r_dig <= r_dig - 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_trace_gen.sv
// Self-checking bench for cpu_trace_gen: string-level line model, per-cycle
// character checker, timing/backpressure/reset/back-to-back scenarios.
`timescale 1ns/1ps
module tb_cpu_trace_gen;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cpu_trace_gen_if bus();

   cpu_trace_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef TRACE_GEN_ZERO_PAD_EN
   localparam string L_REG  = "^0007@00003000: $03 <= 0000abcd#";
   localparam string L_ZERO = "^0000@00000000: $00 <= 00000000#";
   localparam string L_RST  = "^0012@0abc0000: $05 <= 00000055#";
`else
   localparam string L_REG  = "^7@00003000: $3 <= 0000abcd#";
   localparam string L_ZERO = "^0@00000000: $0 <= 00000000#";
   localparam string L_RST  = "^12@0abc0000: $5 <= 00000055#";
`endif
   localparam string L_MEM  = "^1234@bfc00004: *00000010 <= ffffffff#";
   localparam string L_SAT  = "^9999@12345678: $31 <= 9abcdef0#";

   int    n_chk = 0;
   int    n_fail = 0;
   int    cyc = 0;
   byte   exp_q[$];
   int    lines = 0;
   int    chars_in_line = 0;
   int    first_cyc = 0;
   int    hash_cyc = 0;
   int    line_len = 0;
   bit    in_line = 0;
   bit    prev_stall = 0;
   logic [7:0] prev_char = 8'h00;
   string cur_line = "";
   string last_line = "";
   bit    rand_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
      end
   endtask

   // Reference line built directly from the textual format.
   function automatic string model_line(input bit is_mem, input int t, input logic [31:0] pc,
                                        input int rg, input logic [31:0] addr,
                                        input logic [31:0] data);
      int    ts;
      string ts_s;
      string fld;
      ts = (t > 9999) ? 9999 : t;
`ifdef TRACE_GEN_ZERO_PAD_EN
      ts_s = $sformatf("%0d%0d%0d%0d", ts / 1000, (ts / 100) % 10, (ts / 10) % 10, ts % 10);
      fld  = is_mem ? $sformatf("*%h", addr) : $sformatf("$%0d%0d", rg / 10, rg % 10);
`else
      ts_s = $sformatf("%0d", ts);
      fld  = is_mem ? $sformatf("*%h", addr) : $sformatf("$%0d", rg);
`endif
      return $sformatf("^%s@%h: %s <= %h#", ts_s, pc, fld, data);
   endfunction

   // Must be called at a falling edge; returns acceptance cycle in acc.
   task automatic send(input bit is_mem, input int t, input logic [31:0] pc, input int rg,
                       input logic [31:0] addr, input logic [31:0] data, output int acc);
      string s;
      int    n;
      n = 0;
      bus.in_valid  = 1'b1;
      bus.in_is_mem = is_mem;
      bus.in_time   = 14'(t);
      bus.in_pc     = pc;
      bus.in_reg    = 5'(rg);
      bus.in_addr   = addr;
      bus.in_data   = data;
      while (bus.in_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", n);
      end
      acc = cyc;
      s = model_line(is_mem, t, pc, rg, addr, data);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      $display("event t=%0d pc=%h mem=%0d accepted at cycle %0d: %s", t, pc, is_mem, acc, s);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_lines(input int target);
      int n;
      n = 0;
      while (lines < target && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (lines < target) begin
         n_chk++;
         n_fail++;
         $display("FAIL line_timeout: %0d lines seen, required %0d", lines, target);
      end
      @(negedge clk);
   endtask

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Per-cycle checker: every accepted char against the model queue, plus
   // stall stability and no valid gaps inside a line.
   always @(negedge clk) begin
      if (reset) begin
         if (prev_stall) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_char", bus.out_char, prev_char);
         end
         if (in_line) chk("valid_midline", bus.out_valid, 1);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_char: got %02h, required none", bus.out_char);
            end else begin
               chk("char", bus.out_char, exp_q.pop_front());
            end
            if (bus.out_char == 8'h5e) begin
               first_cyc     = cyc;
               chars_in_line = 0;
               cur_line      = "";
            end
            chars_in_line++;
            cur_line = $sformatf("%s%c", cur_line, bus.out_char);
            if (bus.out_char == 8'h23) begin
               hash_cyc  = cyc;
               line_len  = chars_in_line;
               last_line = cur_line;
               lines++;
               in_line   = 0;
               $display("line %0d done at cycle %0d: %s", lines, cyc, cur_line);
            end else begin
               in_line = 1;
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_char  = bus.out_char;
      end else begin
         prev_stall    = 0;
         in_line       = 0;
         chars_in_line = 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    acc;
      int    acc2;
      int    h1;
      int    n;
      string s;
      bus.in_valid  = 1'b0;
      bus.in_is_mem = 1'b0;
      bus.in_time   = '0;
      bus.in_pc     = '0;
      bus.in_reg    = '0;
      bus.in_addr   = '0;
      bus.in_data   = '0;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_char", bus.out_char, 0);
      reset = 1'b1;
      @(negedge clk);

      // Register line with full timing checks
      s = model_line(0, 7, 32'h00003000, 3, 32'h0, 32'h0000abcd);
      chk_str("model_reg", s, L_REG);
      send(0, 7, 32'h00003000, 3, 32'h0, 32'h0000abcd, acc);
      chk("conv_in_ready", bus.in_ready, 0);
      chk("conv_out_valid", bus.out_valid, 0);
      repeat (13) @(negedge clk);
      chk("conv_end_valid", bus.out_valid, 0);
      wait_lines(1);
      chk("first_char_cycle", first_cyc - acc, 15);
      chk("hash_cycle", hash_cyc - acc, 14 + L_REG.len());
      chk("line_len", line_len, L_REG.len());
      chk("ready_after_hash", bus.in_ready, 1);
      chk("ready_cycle", cyc - acc, 15 + L_REG.len());
      chk_str("reg_line", last_line, L_REG);

      // Memory line
      s = model_line(1, 1234, 32'hbfc00004, 0, 32'h10, 32'hffffffff);
      chk_str("model_mem", s, L_MEM);
      send(1, 1234, 32'hbfc00004, 0, 32'h10, 32'hffffffff, acc);
      wait_lines(2);
      chk_str("mem_line", last_line, L_MEM);

      // Boundaries: zero time/reg, saturated time with reg 31
      send(0, 0, 32'h0, 0, 32'h0, 32'h0, acc);
      wait_lines(3);
      chk_str("zero_line", last_line, L_ZERO);
      s = model_line(0, 16383, 32'h12345678, 31, 32'h0, 32'h9abcdef0);
      chk_str("model_sat", s, L_SAT);
      send(0, 16383, 32'h12345678, 31, 32'h0, 32'h9abcdef0, acc);
      wait_lines(4);
      chk_str("sat_line", last_line, L_SAT);

      // Random backpressure
      rand_mode = 1;
      send(0, 56, 32'hdeadbeef, 17, 32'h0, 32'h0badf00d, acc);
      wait_lines(5);
      chk_str("bp_reg_line", last_line, model_line(0, 56, 32'hdeadbeef, 17, 32'h0, 32'h0badf00d));
      send(1, 10000, 32'h0, 9, 32'hcafe0123, 32'h1, acc);
      wait_lines(6);
      chk_str("bp_mem_line", last_line, model_line(1, 10000, 32'h0, 9, 32'hcafe0123, 32'h1));
      rand_mode = 0;
      repeat (3) @(negedge clk);

      // Reset mid-line after "^12@0"
      send(0, 12, 32'h0abc0000, 5, 32'h0, 32'h55, acc);
      n = 0;
      while (!(in_line && chars_in_line == 5) && n < 400) begin
         @(posedge clk);
         n++;
      end
      chk("midline_reached", chars_in_line, 5);
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst_out_valid", bus.out_valid, 0);
      chk("async_rst_in_ready", bus.in_ready, 1);
      chk("async_rst_out_char", bus.out_char, 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abandoned_lines", lines, 6);
      send(0, 12, 32'h0abc0000, 5, 32'h0, 32'h55, acc);
      wait_lines(7);
      chk_str("post_reset_line", last_line, L_RST);

      // Back-to-back events with in_valid held high
      send(0, 1, 32'h00000100, 1, 32'h0, 32'h11, acc);
      send(1, 2, 32'h00000104, 0, 32'h2000, 32'h22, acc2);
      h1 = hash_cyc;
      chk("b2b_accept_gap", acc2 - h1, 1);
      wait_lines(9);
      chk_str("b2b_second_line", last_line, model_line(1, 2, 32'h00000104, 0, 32'h2000, 32'h22));

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("idle_out_valid", bus.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_trace_gen.md
# cpu_trace_gen

Formats one CPU write-back event per transaction into the ASCII trace line accepted by the CPU trace checker, emitting one character per handshake. It sits at the CPU's commit point, and its character stream feeds the checker or a UART/log sink directly. Lines are `^<time>@<pc>: $<reg> <= <data>#` for register writes and `^<time>@<pc>: *<addr> <= <data>#` for memory writes.

## Interface
Parameters: none; all widths are fixed by the line format.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low.
- in_valid  input  1  event offered.
- in_ready  output  1  high only in IDLE; the event is accepted when in_valid && in_ready.
- in_is_mem  input  1  0: register write (`$`); 1: memory write (`*`).
- in_time  input  14  cycle stamp, binary; values above 9999 saturate to 9999.
- in_pc  input  32  instruction address.
- in_reg  input  5  destination register, 0..31.
- in_addr  input  32  memory address, used when in_is_mem=1.
- in_data  input  32  written value.
- out_valid  output  1  char is valid.
- out_char  output  8  ASCII character.
- out_ready  input  1  sink accepts the char on the cycle where out_valid && out_ready.

## Operation
- All input fields are registered on acceptance. Inputs are don't-care at any other time.
- States:
  - IDLE
  - CONV: 14-cycle binary-to-BCD conversion of the saturated time.
  - CARET
  - TIME: decimal digits, most significant first.
  - AT
  - PC: 8 hex digits.
  - COLON
  - SP1
  - TAG: `$` or `*`.
  - FIELD: reg in decimal, or addr as 8 hex digits.
  - SP2
  - LT
  - EQ
  - SP3
  - DATA: 8 hex digits.
  - HASH
  - After HASH, return to IDLE.
- Hex digits are lowercase `0-9a-f`, always 8 digits with zero-fill, emitted from nibble 7 down to nibble 0. A 3-bit nibble counter wraps 7→0; the state exits when the count reaches 0.
- Decimal fields, time and reg, suppress leading zeros. The value 0 is printed as the single digit `0`. Time uses 1–4 digits and reg uses 1–2 digits.
- Reg tens and units digits are derived combinationally from the registered in_reg.
- Exactly one space is emitted at each of SP1, SP2 and SP3.
- An emitting state advances only when out_valid && out_ready. When out_ready is low, out_char and out_valid hold stable.
- reset low, at any time including mid-line: state→IDLE, counters→0 and out_valid→0 immediately. A partially emitted line is abandoned. The sink treats the following `^` as a resync.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - out_char=8'h00
- Cycle 0: the event is accepted, and in_ready drops on the following cycle.
- Cycles 1–14: CONV, with out_valid=0.
- Cycle 15: first `^` with out_valid=1.
- With out_ready held high, one character per cycle, so a line of N characters completes at cycle 14+N.
- in_ready returns to 1 in the cycle after HASH is accepted. Back-to-back events therefore cost N+15 cycles each.
- out_valid never deasserts mid-line except on reset.

## Configuration
- TRACE_GEN_ZERO_PAD_EN, when defined:
  - time is always printed as 4 digits and reg as 2 digits, with leading zeros (`^0007@…$03`).
- When not defined:
  - leading-zero suppression as described in Operation.
- Both forms are valid checker input.
- The CONV latency is identical in both builds.

## Structure
- Package trace_gen_pkg contains:
  - the state enum;
  - ASCII constants: CARET, AT, COLON, SPACE, DOLLAR, STAR, LT, EQ, HASH;
  - a nibble-to-ASCII hex function;
  - the TIME_MAX=9999 constant.
- Sub-module bin2bcd_seq: 14-bit shift-add-3 converter with start/done, 14 cycles, producing four 4-bit BCD digits. It is instantiated once.

## Test plan
- Register line: time=7, pc=32'h00003000, reg=3, data=32'h0000abcd, out_ready=1 → `^7@00003000: $3 <= 0000abcd#`, 28 characters, first char at cycle 15, in_ready high at cycle 43.
- Memory line: time=1234, pc=32'hbfc00004, addr=32'h10, data=32'hffffffff → `^1234@bfc00004: *00000010 <= ffffffff#`.
- Boundaries:
  - time=0, reg=0 → `^0@…: $0 <= …#`;
  - time=14'h3fff → digits `9999`;
  - reg=31 → `$31`.
- Backpressure: toggle out_ready randomly → the character sequence is identical to the unstalled run, and out_char is stable while out_valid && !out_ready.
- Reset mid-line: drop reset after `^12@0` → out_valid=0 and in_ready=1 asynchronously. A new event then produces a complete, correct line.
- Back-to-back events: in_valid held high with two events → lines emitted in order, no characters interleaved, the second accepted exactly one cycle after the first HASH.
